// File: rtl/pupil_centroid_calc.sv
// Purpose: per-frame pupil centroid. Thresholds an N-lane pixel stream inside a ROI, accumulates count/X/Y sums, divides at frame end.
// Latency: oVALID pulses SUM_WIDTH+2 cycles after the edge that samples the iFVAL fall; a queued second frame follows its predecessor's DIV_DONE.
// Backpressure: none; the stream is never stalled. One pending result slot, and a newer frame end overwrites it.
module pupil_centroid_calc #(
    parameter int PIXEL_WIDTH = 8,
    parameter int LANES       = 2,
    parameter int COORD_WIDTH = 11,
    parameter int CNT_WIDTH   = 20,
    parameter int SUM_WIDTH   = 31
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         iFVAL,
    input  logic                         iLVAL,
    input  logic                         iDVAL,
    input  logic [LANES*PIXEL_WIDTH-1:0] iDATA,
    input  logic [PIXEL_WIDTH-1:0]       iTHRESHOLD,
    input  logic                         iPOLARITY,
    input  logic [COORD_WIDTH-1:0]       iROI_X0,
    input  logic [COORD_WIDTH-1:0]       iROI_X1,
    input  logic [COORD_WIDTH-1:0]       iROI_Y0,
    input  logic [COORD_WIDTH-1:0]       iROI_Y1,
    input  logic [CNT_WIDTH-1:0]         iMIN_COUNT,
    output logic                         oBUSY,
    output logic                         oVALID,
    output logic                         oFOUND,
    output logic [COORD_WIDTH-1:0]       oX,
    output logic [COORD_WIDTH-1:0]       oY,
    output logic [CNT_WIDTH-1:0]         oCOUNT
);

    localparam int STEP_W = $clog2(SUM_WIDTH) + 1;

    typedef enum logic {IDLE, ACCUM} acc_state_t;
    typedef enum logic [1:0] {DIV_IDLE, DIV_RUN, DIV_DONE} div_state_t;

    acc_state_t acc_state;
    div_state_t div_state;

    // Stream edge detection
    logic fval_q, lval_q;
    logic fval_rise, fval_fall, lval_fall, frame_end, beat;

    // Accumulator state and per-frame sampled controls
    logic [COORD_WIDTH-1:0] x, y;
    logic                   x_sat;
    logic [CNT_WIDTH-1:0]   count;
    logic [SUM_WIDTH-1:0]   sum_x, sum_y;
    logic [PIXEL_WIDTH-1:0] thr;
    logic                   pol;
    logic [COORD_WIDTH-1:0] roi_x0, roi_x1, roi_y0, roi_y1;

    // Per-beat contributions
    logic [CNT_WIDTH-1:0]   beat_p;
    logic [SUM_WIDTH-1:0]   beat_sx, beat_sy;
    logic [COORD_WIDTH:0]   lane_x;
    logic [PIXEL_WIDTH-1:0] pix;
    logic                   pass;
    logic [CNT_WIDTH:0]     cnt_sum;
    logic [COORD_WIDTH:0]   x_adv;

    // Divider operands, pending slot and datapath
    logic                   div_start;
    logic [CNT_WIDTH-1:0]   op_cnt, pend_cnt;
    logic [SUM_WIDTH-1:0]   op_sx, op_sy, pend_sx, pend_sy;
    logic                   pend_vld;
    logic [CNT_WIDTH-1:0]   rem_x, rem_y;
    logic [SUM_WIDTH-1:0]   quo_x, quo_y;
    logic [STEP_W-1:0]      step;
    logic                   found_q;

    assign fval_rise = iFVAL & ~fval_q;
    assign fval_fall = ~iFVAL & fval_q;
    assign lval_fall = ~iLVAL & lval_q;
    assign frame_end = (acc_state == ACCUM) && fval_fall;
    assign beat      = (acc_state == ACCUM) && iFVAL && iLVAL && iDVAL;

    // One restoring-division step: shift in the next dividend bit, subtract if it fits.
    function automatic logic [CNT_WIDTH+SUM_WIDTH-1:0] div_step(
        input logic [CNT_WIDTH-1:0] rem,
        input logic [SUM_WIDTH-1:0] quo,
        input logic [CNT_WIDTH-1:0] dvs
    );
        logic [CNT_WIDTH:0] trial;
        trial = {rem, quo[SUM_WIDTH-1]};
        if (trial >= {1'b0, dvs}) begin
            trial = trial - {1'b0, dvs};
            return {trial[CNT_WIDTH-1:0], quo[SUM_WIDTH-2:0], 1'b1};
        end
        return {trial[CNT_WIDTH-1:0], quo[SUM_WIDTH-2:0], 1'b0};
    endfunction

    // Qualify each lane of the current beat and sum its contribution
    always_comb begin
        beat_p  = '0;
        beat_sx = '0;
        beat_sy = '0;
        lane_x  = '0;
        pix     = '0;
        pass    = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            lane_x = {1'b0, x} + (COORD_WIDTH+1)'(k);
            pix    = iDATA[k*PIXEL_WIDTH +: PIXEL_WIDTH];
            pass   = pol ? (pix < thr) : (pix >= thr);
            if (beat && pass && !x_sat && !lane_x[COORD_WIDTH] &&
                lane_x[COORD_WIDTH-1:0] >= roi_x0 && lane_x[COORD_WIDTH-1:0] <= roi_x1 &&
                y >= roi_y0 && y <= roi_y1) begin
                beat_p  = beat_p + CNT_WIDTH'(1);
                beat_sx = beat_sx + SUM_WIDTH'(lane_x[COORD_WIDTH-1:0]);
                beat_sy = beat_sy + SUM_WIDTH'(y);
            end
        end
        cnt_sum = {1'b0, count} + {1'b0, beat_p};
        x_adv   = {1'b0, x} + (COORD_WIDTH+1)'(LANES);
    end

    // Accumulator FSM: frame/line tracking, coordinate counters and sums
    always_ff @(posedge CLK) begin
        if (RST) begin
            acc_state <= IDLE;
            // Held high so a frame already in progress after reset is not seen as a new rise.
            fval_q    <= 1'b1;
            lval_q    <= 1'b0;
            x         <= '0;
            y         <= '0;
            x_sat     <= 1'b0;
            count     <= '0;
            sum_x     <= '0;
            sum_y     <= '0;
            thr       <= '0;
            pol       <= 1'b0;
            roi_x0    <= '0;
            roi_x1    <= '0;
            roi_y0    <= '0;
            roi_y1    <= '0;
        end else begin
            fval_q <= iFVAL;
            lval_q <= iLVAL;
            case (acc_state)
                IDLE: begin
                    if (fval_rise) begin
                        x         <= '0;
                        y         <= '0;
                        x_sat     <= 1'b0;
                        count     <= '0;
                        sum_x     <= '0;
                        sum_y     <= '0;
                        thr       <= iTHRESHOLD;
                        pol       <= iPOLARITY;
                        roi_x0    <= iROI_X0;
                        roi_x1    <= iROI_X1;
                        roi_y0    <= iROI_Y0;
                        roi_y1    <= iROI_Y1;
                        acc_state <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (fval_fall) begin
                        acc_state <= IDLE;
                    end else begin
                        if (beat) begin
                            count <= cnt_sum[CNT_WIDTH] ? '1 : cnt_sum[CNT_WIDTH-1:0];
                            sum_x <= sum_x + beat_sx;
                            sum_y <= sum_y + beat_sy;
                            if (x_adv[COORD_WIDTH]) begin
                                x     <= '1;
                                x_sat <= 1'b1;
                            end else begin
                                x <= x_adv[COORD_WIDTH-1:0];
                            end
                        end
                        if (lval_fall) begin
                            x     <= '0;
                            x_sat <= 1'b0;
                            y     <= (y == '1) ? y : y + COORD_WIDTH'(1);
                        end
                    end
                end
                default: acc_state <= IDLE;
            endcase
        end
    end

    // Divider FSM: operand capture/queueing, X and Y long division in parallel, result update
    always_ff @(posedge CLK) begin
        if (RST) begin
            div_state <= DIV_IDLE;
            div_start <= 1'b0;
            op_cnt    <= '0;
            op_sx     <= '0;
            op_sy     <= '0;
            pend_vld  <= 1'b0;
            pend_cnt  <= '0;
            pend_sx   <= '0;
            pend_sy   <= '0;
            rem_x     <= '0;
            rem_y     <= '0;
            quo_x     <= '0;
            quo_y     <= '0;
            step      <= '0;
            found_q   <= 1'b0;
            oBUSY     <= 1'b0;
            oVALID    <= 1'b0;
            oFOUND    <= 1'b0;
            oX        <= '0;
            oY        <= '0;
            oCOUNT    <= '0;
        end else begin
            div_start <= 1'b0;
            oVALID    <= 1'b0;
            case (div_state)
                DIV_IDLE: begin
                    if (div_start) begin
                        rem_x     <= '0;
                        rem_y     <= '0;
                        quo_x     <= op_sx;
                        quo_y     <= op_sy;
                        step      <= '0;
                        found_q   <= (op_cnt != '0) && (op_cnt >= iMIN_COUNT);
                        oBUSY     <= 1'b1;
                        div_state <= DIV_RUN;
                    end
                end
                DIV_RUN: begin
                    // A gated result skips the arithmetic but keeps the fixed cycle count.
                    if (found_q) begin
                        {rem_x, quo_x} <= div_step(rem_x, quo_x, op_cnt);
                        {rem_y, quo_y} <= div_step(rem_y, quo_y, op_cnt);
                    end
                    step <= step + STEP_W'(1);
                    if (step == STEP_W'(SUM_WIDTH - 1)) begin
                        oBUSY     <= 1'b0;
                        div_state <= DIV_DONE;
                    end
                end
                DIV_DONE: begin
                    oVALID <= 1'b1;
                    oCOUNT <= op_cnt;
                    oFOUND <= found_q;
                    if (found_q) begin
                        oX <= quo_x[COORD_WIDTH-1:0];
                        oY <= quo_y[COORD_WIDTH-1:0];
                    end
                    if (pend_vld) begin
                        op_cnt    <= pend_cnt;
                        op_sx     <= pend_sx;
                        op_sy     <= pend_sy;
                        pend_vld  <= 1'b0;
                        div_start <= 1'b1;
                    end
                    div_state <= DIV_IDLE;
                end
                default: div_state <= DIV_IDLE;
            endcase
            // Frame end goes straight to the operands when the divider can take it, else to the pending slot.
            if (frame_end) begin
                if ((div_state == DIV_IDLE && !div_start) || (div_state == DIV_DONE && !pend_vld)) begin
                    op_cnt    <= count;
                    op_sx     <= sum_x;
                    op_sy     <= sum_y;
                    div_start <= 1'b1;
                end else begin
                    pend_cnt <= count;
                    pend_sx  <= sum_x;
                    pend_sy  <= sum_y;
                    pend_vld <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/pupil_centroid_calc.md
Name: pupil_centroid_calc

Overview:
- Streaming per-frame centroid engine for the camera-side (CCLK) pipeline. It takes the registered Camera Link pixel stream and thresholds each pixel.
- Qualifying pixels are those inside a programmable ROI that pass the threshold test. The block accumulates their count, X sum and Y sum.
- At frame end it divides the sums by the count to produce the (X, Y) pupil centroid.
- Generalises the Y-only gravity calculator: both axes, N pixel lanes per clock, ROI, bright/dark polarity and a minimum-count gate. Runs directly on the stream, with no line memory.

Parameters:
- PIXEL_WIDTH, 8, bits per pixel.
- LANES, 2, pixels per clock beat; lane 0 is the leftmost pixel.
- COORD_WIDTH, 11, width of X/Y coordinate counters and of the results.
- CNT_WIDTH, 20, width of the qualifying-pixel counter.
- SUM_WIDTH, 31, width of the X/Y sums; must be >= COORD_WIDTH+CNT_WIDTH.

Ports:
- CLK  in  1  pixel clock (CCLK domain).
- RST  in  1  synchronous reset, active-high.
- iFVAL  in  1  frame valid, active-high.
- iLVAL  in  1  line valid, active-high.
- iDVAL  in  1  data valid, active-high.
- iDATA  in  LANES*PIXEL_WIDTH  pixel lanes; lane k occupies bits [k*PIXEL_WIDTH +: PIXEL_WIDTH].
- iTHRESHOLD  in  PIXEL_WIDTH  binarisation threshold.
- iPOLARITY  in  1  0 = a pixel qualifies if pixel >= threshold; 1 = a pixel qualifies if pixel < threshold (dark pupil).
- iROI_X0, iROI_X1, iROI_Y0, iROI_Y1  in  COORD_WIDTH each  inclusive ROI bounds.
- iMIN_COUNT  in  CNT_WIDTH  minimum qualifying count for a valid result.
- oBUSY  out  1  divider running.
- oVALID  out  1  one-cycle pulse when a result is ready.
- oFOUND  out  1  last result valid (count >= iMIN_COUNT and count != 0).
- oX, oY  out  COORD_WIDTH each  centroid, truncated.
- oCOUNT  out  CNT_WIDTH  qualifying count of the last frame.

Behaviour:
- Reset: all outputs are 0, the accumulator FSM goes to IDLE and the divider FSM goes to DIV_IDLE.
  - After a reset that occurs mid-frame, the block ignores the current frame and starts accumulating only at the next iFVAL rising edge.
- Edge detection: iFVAL and iLVAL are registered internally; a rise or fall is detected by comparing the current input with the registered value.

Accumulator FSM:
- IDLE -> ACCUM on an iFVAL rise.
  - On entry: clear x, y, count, sumX and sumY.
  - Sample iTHRESHOLD, iPOLARITY and the ROI bounds; these are held for the whole frame.
- ACCUM, on each beat with iFVAL & iLVAL & iDVAL:
  - Lane k has coordinate (x+k, y); x then advances by LANES.
  - x saturates at all-ones; pixels whose coordinate saturates are ignored.
- ACCUM, on an iLVAL fall: x <= 0 and y <= y+1 (y saturating).
- A pixel qualifies if X0 <= x+k <= X1, Y0 <= y <= Y1 and it passes the threshold test. If X0 > X1 or Y0 > Y1, nothing qualifies.
- Per beat, with p = number of qualifying lanes:
  - count += p, saturating at all-ones.
  - sumX += sum of the qualifying x+k values.
  - sumY += y*p.
- ACCUM -> IDLE on an iFVAL fall.
  - count, sumX and sumY are copied to the divider operand registers.
  - The divider is started (a start pulse to the divider FSM).
- Beats with iDVAL=0 are ignored. Beats outside iFVAL/iLVAL are ignored.

Divider FSM:
- DIV_IDLE -> DIV_RUN on start; oBUSY=1 while in DIV_RUN.
- DIV_RUN performs restoring long division for X and Y in parallel, one quotient bit per cycle, for SUM_WIDTH cycles.
  - If the latched count < iMIN_COUNT or count == 0, no division is performed; the cycle count is still SUM_WIDTH.
- DIV_RUN -> DIV_DONE -> DIV_IDLE. In DIV_DONE:
  - oVALID = 1 and oCOUNT is updated.
  - oFOUND is set according to the gate above.
  - oX/oY take the low COORD_WIDTH quotient bits if found; otherwise they hold their previous values.
- Latency: oVALID goes high exactly SUM_WIDTH+2 cycles after the clock edge that samples the iFVAL fall.
- Overlap: a new frame may start while DIV_RUN is active, because the accumulators are independent of the operand registers.
  - If another iFVAL fall arrives while DIV_RUN is active, the running division completes first.
  - The new operands are queued in a one-deep pending slot and their division starts on the cycle after DIV_DONE.
  - A third fall while a division is pending overwrites the pending slot.
- iMIN_COUNT is sampled at the start of the divide.

Test Plan:
- Lanes and window: LANES=2, 16x8 frame, all pixels 0x10, threshold 0x80, polarity 1, ROI (4..7, 2..3) -> oCOUNT=8, oX=5, oY=2 (truncated from 5.5 / 2.5), oFOUND=1, oVALID exactly SUM_WIDTH+2 cycles after the FVAL fall.
- Bright spot: single pixel 0xFF at (9,5), polarity 0, threshold 0x80, full ROI, iMIN_COUNT=1 -> oX=9, oY=5, oCOUNT=1, oFOUND=1.
- Minimum-count gate and hold: previous result (9,5), next frame with 3 qualifying pixels and iMIN_COUNT=4 -> oFOUND=0, oCOUNT=3, oX/oY stay at 9/5, oVALID still pulses.
- DVAL gating and inverted ROI: iDVAL toggled every other beat -> coordinates advance only on valid beats and the centroid matches the compacted image; ROI X0=10, X1=3 -> oCOUNT=0, oFOUND=0.
- Back-to-back frames: the second frame starts 2 cycles after the first FVAL fall -> both results are correct, the second is delivered after the first DIV_DONE, and no accumulation is corrupted.
- Reset mid-frame: assert RST for 1 cycle at line 3 -> all outputs are 0; no oVALID is produced for that frame; the next full frame produces a correct result.
